// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing one 4:1 mux channel among four requesters.
// It limits each grant to MAX_BURST accepted beats and re-arbitrates without an idle bubble.
//
// state | meaning
// IDLE  | no owner, gnt=0, waiting for any req
// GRANT | channel owned by requester sel, beats counted on vld & rdy
module mux_rr_sched #(
  parameter int MAX_BURST = 4,
  parameter int BURST_W   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rdy,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       vld,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [BURST_W-1:0] LAST_BEAT = BURST_W'(MAX_BURST - 1);

  state_t             state;
  logic [BURST_W-1:0] count;
  logic [1:0]         ptr;
  logic [2:0]         arb_idle;
  logic [2:0]         arb_rel;
  logic               beat;
  logic               release_g;

  // Returns {found, index}; the search starts after last and examines last itself at the end.
  function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] last);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign arb_idle  = arbitrate(req, ptr);
  assign arb_rel   = arbitrate(req, sel);
  assign busy      = (state == GRANT);
  assign vld       = busy & req[sel];
  assign beat      = vld & rdy;
  assign release_g = busy & (~req[sel] | (beat & (count == LAST_BEAT)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      count <= '0;
      ptr   <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (arb_idle[2]) begin
            state <= GRANT;
            gnt   <= 4'b0001 << arb_idle[1:0];
            sel   <= arb_idle[1:0];
            count <= '0;
          end
        end
        GRANT: begin
          if (release_g) begin
            ptr <= sel;
            if (arb_rel[2]) begin
              gnt   <= 4'b0001 << arb_rel[1:0];
              sel   <= arb_rel[1:0];
              count <= '0;
            end else begin
              // sel deliberately keeps its last value when going idle
              state <= IDLE;
              gnt   <= 4'b0000;
            end
          end else if (beat) begin
            count <= count + BURST_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Bench for mux_rr_sched: directed scenarios with literal expectations plus a
// randomized run compared every cycle against an owner/last-winner reference model.
module tb_mux_rr_sched;

  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       rdy = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       vld;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit en       = 1'b0;

  // reference model: owner -1 means idle
  int m_owner = -1;
  int m_sel   = 0;
  int m_count = 0;
  int m_last  = 3;
  int w;
  bit m_beat;

  mux_rr_sched #(.MAX_BURST(MAX_BURST), .BURST_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .rdy(rdy),
    .gnt(gnt), .sel(sel), .vld(vld), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_arb(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_sel = 0; m_count = 0; m_last = 3;
    end else if (m_owner < 0) begin
      w = m_arb(req, m_last);
      if (w >= 0) begin m_owner = w; m_sel = w; m_count = 0; end
    end else begin
      m_beat = req[m_owner] && rdy;
      if (!req[m_owner] || (m_beat && m_count == MAX_BURST - 1)) begin
        m_last = m_owner;
        w = m_arb(req, m_last);
        if (w >= 0) begin m_owner = w; m_sel = w; m_count = 0; end
        else m_owner = -1;
      end else if (m_beat) begin
        m_count++;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("model_gnt",  {28'd0, gnt},  (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("model_sel",  {30'd0, sel},  32'(m_sel));
      chk("model_busy", {31'd0, busy}, (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("model_vld",  {31'd0, vld},  ((m_owner >= 0) && req[m_sel]) ? 32'd1 : 32'd0);
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; req = 4'b0000; rdy = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    en = 1'b1;

    // reset holds outputs at zero while req toggles
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      req = (i % 2 == 0) ? 4'hF : 4'h0;
      @(negedge clk);
      chk("rst_gnt", {28'd0, gnt}, 32'd0);
      chk("rst_sel", {30'd0, sel}, 32'd0);
      chk("rst_vld", {31'd0, vld}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
    end

    // rotation: 4 beats each to 0,1,2,3 then back to 0 with no gap
    @(posedge clk); #2;
    rst = 1'b0; req = 4'hF; rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_gnt", {28'd0, gnt}, 32'd1);
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clk);
      chk("rot_sel", {30'd0, sel}, 32'((i / 4) % 4));
      chk("rot_vld", {31'd0, vld}, 32'd1);
    end

    // single requester keeps the channel continuously
    do_reset();
    req = 4'b0100; rdy = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("single_gnt", {28'd0, gnt}, 32'h4);
      chk("single_vld", {31'd0, vld}, 32'd1);
    end

    // backpressure: count holds while rdy=0, then exactly 4 beats
    do_reset();
    req = 4'b0010; rdy = 1'b0;
    @(posedge clk); #2;
    req = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_gnt", {28'd0, gnt}, 32'h2);
    end
    @(posedge clk); #2;
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_beat_sel", {30'd0, sel}, 32'd1);
      chk("bp_beat_vld", {31'd0, vld}, 32'd1);
    end
    @(negedge clk);
    chk("bp_next_gnt", {28'd0, gnt}, 32'h1);

    // early drop of requester 3 after two beats
    do_reset();
    req = 4'b1000; rdy = 1'b1;
    @(posedge clk); #2;
    req = 4'b1001;
    @(posedge clk);
    @(posedge clk); #2;
    req = 4'b0001;
    @(negedge clk);
    chk("drop_vld", {31'd0, vld}, 32'd0);
    chk("drop_gnt_hold", {28'd0, gnt}, 32'h8);
    @(negedge clk);
    chk("drop_next_gnt", {28'd0, gnt}, 32'h1);

    // asynchronous reset between edges during a grant
    do_reset();
    req = 4'hF; rdy = 1'b1;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_gnt", {28'd0, gnt}, 32'd0);
    chk("arst_vld", {31'd0, vld}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("arst_restart_gnt", {28'd0, gnt}, 32'h1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      rdy = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
